// File: rtl/mxu_stream_sequencer.sv
// Initiator for the MXU wrapper: issues operand vectors, follows them through the
// skew/core/deskew pipeline with a tag shift register and buffers results in a FIFO.
module mxu_stream_sequencer #(
  parameter int M              = 3,
  parameter int K              = 3,
  parameter int max_data_width = 4,
  parameter int CORE_LAT       = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int TYPE_W         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [TYPE_W-1:0]             cfg_type,
  input  logic                          cfg_test,
  output logic                          busy,
  output logic                          done,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [K*max_data_width-1:0]   s_data,
  input  logic [M*max_data_width-1:0]   s_weight,
  input  logic                          s_last,
  output logic [TYPE_W-1:0]             mxu_data_type,
  output logic                          mxu_enable,
  output logic                          mxu_enable_in_ff,
  output logic                          mxu_enable_out_ff,
  output logic                          mxu_test_mode,
  output logic [K*max_data_width-1:0]   mxu_input_data,
  output logic [M*max_data_width-1:0]   mxu_weight,
  input  logic [M*max_data_width-1:0]   mxu_y,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [M*max_data_width-1:0]   m_data,
  output logic                          m_last
);
  localparam int L  = (K - 1) + CORE_LAT + (M - 1);
  localparam int RW = M * max_data_width;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(L + 1);
  localparam int SW = CW + FW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [TYPE_W-1:0] type_q;
  logic              test_q;
  logic [L-1:0]      tag_valid, tag_last;
  logic [FW-1:0]     inflight;
  logic [RW:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              issue, capture, pop;

  // Credits count both buffered and in-flight results so a capture never finds the FIFO full.
  assign s_ready = (state == RUN) && ((SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH));
  assign issue   = s_valid & s_ready;
  assign capture = tag_valid[L-1];
  assign pop     = m_valid & m_ready;

  assign busy              = (state != IDLE);
  assign mxu_enable        = busy;
  assign mxu_enable_in_ff  = busy;
  assign mxu_enable_out_ff = busy;
  assign mxu_data_type     = type_q;
  assign mxu_test_mode     = test_q;
  assign mxu_input_data    = issue ? s_data : '0;
  assign mxu_weight        = issue ? s_weight : '0;

  assign m_valid = (fifo_count != '0);
  assign m_data  = m_valid ? mem[rd_ptr][RW-1:0] : '0;
  assign m_last  = m_valid & mem[rd_ptr][RW];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (cfg_start) state_nxt = RUN;
      RUN:   if (issue && s_last) state_nxt = DRAIN;
      DRAIN: if (inflight == '0) begin
               state_nxt = IDLE;
               done      = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      type_q     <= '0;
      test_q     <= 1'b0;
      tag_valid  <= '0;
      tag_last   <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state  <= state_nxt;
      test_q <= cfg_test;
      if (state == IDLE && cfg_start) type_q <= cfg_type;

      // The wrapper pipeline free-runs while busy, so the tags advance in lockstep with it.
      if (busy) begin
        tag_valid[0] <= issue;
        tag_last[0]  <= issue & s_last;
        for (int i = 1; i < L; i++) begin
          tag_valid[i] <= tag_valid[i-1];
          tag_last[i]  <= tag_last[i-1];
        end
      end

      case ({issue, capture})
        2'b10:   inflight <= inflight + FW'(1);
        2'b01:   inflight <= inflight - FW'(1);
        default: ;
      endcase

      if (capture) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && capture) mem[wr_ptr] <= {tag_last[L-1], mxu_y};
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(capture && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mxu_stream_sequencer.sv
// Scoreboard bench for mxu_stream_sequencer with a delay-line model of the MXU wrapper.
module tb_mxu_stream_sequencer;
  localparam int M = 3, K = 3, W = 4, CORE_LAT = 1, DEPTH = 8;
  localparam int L  = (K - 1) + CORE_LAT + (M - 1);
  localparam int IW = K * W, RW = M * W;

  logic          clk = 1'b0;
  logic          reset, cfg_start, cfg_test, busy, done;
  logic [1:0]    cfg_type, mxu_data_type;
  logic          s_valid, s_ready, s_last;
  logic [IW-1:0] s_data, mxu_input_data;
  logic [RW-1:0] s_weight, mxu_weight, mxu_y, m_data;
  logic          mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff, mxu_test_mode;
  logic          m_valid, m_ready, m_last;

  typedef struct {logic [RW-1:0] data; logic last;} exp_t;
  exp_t exp_q[$];
  int   n_checks = 0, n_pass = 0, accepted = 0, stall_cnt = 0, done_cnt = 0;
  bit   stim_done;

  initial forever #5 clk = ~clk;

  mxu_stream_sequencer #(.M(M), .K(K), .max_data_width(W), .CORE_LAT(CORE_LAT),
                         .FIFO_DEPTH(DEPTH), .TYPE_W(2)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_type(cfg_type), .cfg_test(cfg_test),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_weight(s_weight), .s_last(s_last), .mxu_data_type(mxu_data_type),
    .mxu_enable(mxu_enable), .mxu_enable_in_ff(mxu_enable_in_ff),
    .mxu_enable_out_ff(mxu_enable_out_ff), .mxu_test_mode(mxu_test_mode),
    .mxu_input_data(mxu_input_data), .mxu_weight(mxu_weight), .mxu_y(mxu_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

  // Each result lane is weight[i] times the sum of the input lanes, modulo 2^W.
  function automatic logic [RW-1:0] golden(input logic [IW-1:0] x, input logic [RW-1:0] w);
    logic [RW-1:0] y;
    int s;
    s = 0;
    for (int k = 0; k < K; k++) s += int'(x[k*W +: W]);
    for (int i = 0; i < M; i++) y[i*W +: W] = W'(s * int'(w[i*W +: W]));
    return y;
  endfunction

  // Wrapper model: fixed L-cycle latency, advancing only while enabled.
  logic [RW-1:0] wpipe [L];
  always @(posedge clk) begin
    if (mxu_enable) begin
      wpipe[0] <= golden(mxu_input_data, mxu_weight);
      for (int i = 1; i < L; i++) wpipe[i] <= wpipe[i-1];
    end
  end
  assign mxu_y = wpipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on each result handshake and checks hold stability.
  logic          hold_v = 1'b0, hold_l;
  logic [RW-1:0] hold_d;
  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_v) begin
        check("m_hold_valid", m_valid, 1);
        check("m_hold_data", {m_last, m_data}, {hold_l, hold_d});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("m_unexpected", m_valid, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic send(input logic last);
    logic [IW-1:0] d;
    logic [RW-1:0] w;
    bit ok;
    d = IW'($urandom);
    w = RW'($urandom);
    s_valid = 1'b1; s_data = d; s_weight = w; s_last = last;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
      stall_cnt++;
    end
    if (!ok) check("send_timeout", s_ready, 1);
    else begin
      exp_q.push_back('{golden(d, w), last});
      accepted++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] t);
    @(posedge clk); #1; cfg_start = 1'b1; cfg_type = t;
    @(posedge clk); #1; cfg_start = 1'b0; cfg_type = ~t;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt > d0) break;
      @(negedge clk);
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_m_valid"}, m_valid, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, d0, a0, vmax;
    reset = 1'b0; cfg_start = 1'b0; cfg_type = 2'd0; cfg_test = 1'b1;
    s_valid = 1'b1; s_data = 12'hABC; s_weight = 12'h123; s_last = 1'b1; m_ready = 1'b1;

    // Reset held with traffic present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_enables", {mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff, mxu_test_mode}, 0);
    check("rst_mxu_data", {mxu_input_data, mxu_weight, mxu_data_type}, 0);
    check("rst_m_out", {m_data, m_last}, 0);
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", s_ready, 0);
    check("idle_issue", {mxu_input_data, mxu_weight}, 0);
    check("idle_busy", busy, 0);
    check("test_mode", mxu_test_mode, 1);
    @(posedge clk); #1; cfg_test = 1'b0; s_valid = 1'b0; s_last = 1'b0;

    // Single operation: latency, done pulse, latched type
    start_job(2'b10);
    d0 = done_cnt;
    send(1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check("type_latched", mxu_data_type, 2'b10);
        check("enable_busy", {mxu_enable, mxu_enable_in_ff, mxu_enable_out_ff}, 3'b111);
        check("drain_s_ready", s_ready, 0);
      end
      if (m_valid) break;
    end
    check("single_latency", n, L + 1);
    check("single_done", done, 1);
    check("single_busy_at_done", busy, 1);
    @(negedge clk);
    check("single_busy_after", busy, 0);
    check("single_done_width", done, 0);
    check("single_done_count", done_cnt - d0, 1);
    drain("single_drain");

    // Streaming 20 back-to-back; a second start mid-job is ignored
    start_job(2'b01);
    cfg_start = 1'b1; cfg_type = 2'b11;
    @(posedge clk); #1; cfg_start = 1'b0;
    @(negedge clk);
    check("restart_ignored", mxu_data_type, 2'b01);
    @(posedge clk); #1;
    d0 = done_cnt; stall_cnt = 0;
    for (int i = 0; i < 20; i++) send(i == 19);
    check("stream_stalls", stall_cnt, 0);
    wait_done("stream_done", d0);
    drain("stream_drain");

    // Back-pressure: 12 offered, 8 credits
    @(posedge clk); #1; m_ready = 1'b0;
    start_job(2'b00);
    d0 = done_cnt; a0 = accepted;
    fork
      for (int i = 0; i < 12; i++) send(i == 11);
      begin
        repeat (40) @(negedge clk);
        check("bp_accepted", accepted - a0, 8);
        check("bp_s_ready", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        @(posedge clk); #1; m_ready = 1'b1;
      end
    join
    check("bp_total", accepted - a0, 12);
    wait_done("bp_done", d0);
    drain("bp_drain");

    // Random gaps and random result back-pressure
    start_job(2'b11);
    d0 = done_cnt; stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(i == 39);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        stim_done = 1'b1;
      end
      for (int i = 0; i < 600 && !stim_done; i++) begin
        @(posedge clk); #1; m_ready = ($urandom_range(0, 2) == 0);
      end
    join
    @(posedge clk); #1; m_ready = 1'b1;
    wait_done("rand_done", d0);
    drain("rand_drain");

    // Reset during DRAIN with three results in flight
    start_job(2'b10);
    for (int i = 0; i < 3; i++) send(i == 2);
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_s_ready", s_ready, 0);
    d0 = done_cnt;
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; exp_q.delete(); reset = 1'b1;
    vmax = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid || busy) vmax++;
    end
    check("mid_rst_quiet", vmax, 0);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_ready", s_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
